regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the register file's single write port between the processor writeback stage and up to NUM_REQ peripheral requesters, such as the capacitive-sensor sampler and the game timer, which deposit values into fixed registers.
- Each requester gets a one-entry holding slot.
- Processor writeback has priority; waiting slots are served round-robin.
- A starvation counter raises a stall request to the processor so peripheral data is never indefinitely blocked.
- Output drives the register file write port directly.

## Interface
- NUM_REQ, default 4: number of peripheral requesters (2..8).
- STARVE_LIMIT, default 16: cycles a full slot may wait before cpu_stall is requested (1..255).
- clock  in  1  system clock; all state updates on the rising edge.
- ctrl_reset  in  1  asynchronous, active-low reset.
- cpu_we  in  1  processor writeback write enable.
- cpu_wreg  in  5  processor destination register.
- cpu_wdata  in  32  processor write data.
- cpu_stall  out  1  request for the processor to hold cpu_we low next cycle.
- req_valid  in  NUM_REQ  per-requester valid.
- req_reg  in  5*NUM_REQ  per-requester destination; requester i uses bits [5i+4:5i].
- req_data  in  32*NUM_REQ  per-requester data; requester i uses bits [32i+31:32i].
- req_ready  out  NUM_REQ  per-requester ready; equals slot empty.
- ctrl_writeEnable  out  1  register file write enable.
- ctrl_writeReg  out  5  register file write address.
- data_writeReg  out  32  register file write data.
- grant_src  out  4  source of the current write: 0 = CPU, i+1 = requester i; 0 when idle.
- prot_err  out  1  sticky flag: a requester targeted register 0 or 29.

## Operation
Slot i:
- Transfer when req_valid[i] & req_ready[i] at a rising edge.
  - Slot captures reg and data, becomes full, and req_ready[i] drops.
- Requester holds valid, reg and data stable until the transfer edge.
- Transfer to reg 0 (hardwired zero) or reg 29 (random source): slot is not filled, prot_err sets, and req_ready stays 1.

Arbitration, evaluated each cycle, result registered:
- cpu_we=1 → CPU wins. Outputs take cpu_wreg and cpu_wdata with grant_src=0 and ctrl_writeEnable=1.
  - cpu_wreg=0 still writes; the register file ignores it.
- Otherwise, the first full slot searched from rr_ptr upward (modulo NUM_REQ) wins.
  - Its slot empties at that edge.
  - rr_ptr becomes winner+1 mod NUM_REQ.
- No candidate → ctrl_writeEnable=0, grant_src=0. ctrl_writeReg and data_writeReg hold their last values.

Starvation:
- Each slot has an 8-bit wait counter.
- Counter increments each cycle the slot is full and not granted, saturating at 255. It clears when the slot is granted or empty.
- Any counter ≥ STARVE_LIMIT → cpu_stall=1 (registered), held until no counter ≥ STARVE_LIMIT.
- With cpu_stall=1, the processor keeps cpu_we=0. If cpu_we is nevertheless 1, the CPU still wins.

Reset:
- All slots empty, counters 0, rr_ptr 0, prot_err 0.
- ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, grant_src=0, cpu_stall=0.
- req_ready all 1.
- Reset mid-operation discards slot contents.

## Timing
- CPU write: cpu_we sampled at edge k; ctrl_writeEnable high during cycle k..k+1; the register file commits on the falling edge inside that cycle.
- Peripheral write, uncontended: transfer at edge k, slot full after k, write port driven after edge k+1.
  - Transfer-to-write latency is 1 cycle.
  - req_ready returns 1 after edge k+1.
  - Maximum rate per requester is one write per 2 cycles.
- Filling a slot and granting it cannot coincide, because req_ready=0 while full.
- cpu_stall rises the cycle after a counter reaches STARVE_LIMIT. Under continuous cpu_we, a slot waits at least STARVE_LIMIT+1 cycles.
- No combinational path from req_* or cpu_* to any output.

## Structure
- Package regwr_pkg holds:
  - REG_ZERO=5'd0 and REG_RANDOM=5'd29.
  - REG_ADDR_W=5, DATA_W=32, WAIT_W=8.
  - The grant_src encoding.
- Sub-module regwr_slot: one holding slot plus its wait counter, instantiated NUM_REQ times.
  - Inputs: the capture handshake, grant, and the protected-register check.
  - Outputs: full, reg, data, and starving (counter ≥ STARVE_LIMIT).
- Top level: round-robin search, CPU priority, output registers, prot_err.

## Test plan
- Reset release: all outputs 0, req_ready=4'b1111. One requester 2 sends reg 12, data 0x1A → one cycle later, ctrl_writeEnable=1, ctrl_writeReg=12, data_writeReg=0x1A, grant_src=3.
- Contention: slots 0 and 3 full with rr_ptr=0 while cpu_we=1 for 1 cycle → order is CPU, slot 0, slot 3; rr_ptr ends at 0.
- Round-robin fairness: all 4 requesters re-fill as soon as req_ready rises → grant_src sequence 1,2,3,4,1,2…
- Starvation: cpu_we held high with slot 1 full, STARVE_LIMIT=16 → cpu_stall rises 17 cycles after the transfer. Once cpu_we drops, slot 1 is written on the next cycle and cpu_stall clears.
- Protection: requester 0 sends reg 29, then reg 0 → no write occurs, prot_err=1 and stays set, req_ready[0] stays 1.
- Async reset while slots are full and cpu_stall=1 → all outputs 0 immediately with no clock edge, and the slots are empty after reset is released.

Source files
------------

// File: rtl/regwr_pkg.sv
// Shared constants for the register-file write arbiter: field widths,
// protected register addresses and the grant_src encoding.
package regwr_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WAIT_W     = 8;
  localparam int unsigned GRANT_W    = 4;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO   = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RANDOM = 5'd29;

  // grant_src: 0 for the CPU (and when idle), idx+1 for peripheral requester idx
  localparam logic [GRANT_W-1:0] GRANT_CPU  = 4'd0;
  localparam logic [GRANT_W-1:0] GRANT_IDLE = 4'd0;

  function automatic logic [GRANT_W-1:0] grant_req(input int unsigned idx);
    return GRANT_W'(idx + 1);
  endfunction

  function automatic logic is_protected(input logic [REG_ADDR_W-1:0] addr);
    return (addr == REG_ZERO) || (addr == REG_RANDOM);
  endfunction

endpackage

// File: rtl/regwr_slot.sv
// One-entry holding slot for a peripheral requester, with a saturating
// wait counter that flags starvation once it reaches STARVE_LIMIT.
module regwr_slot
  import regwr_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  valid,
  input  logic                  prot_hit,
  input  logic                  grant,
  input  logic [REG_ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  full,
  output logic [REG_ADDR_W-1:0] slot_reg,
  output logic [DATA_W-1:0]     slot_data,
  output logic                  starving
);

  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      full      <= 1'b0;
      slot_reg  <= '0;
      slot_data <= '0;
      wait_cnt  <= '0;
    end else if (full) begin
      if (grant) begin
        full     <= 1'b0;
        wait_cnt <= '0;
      end else if (wait_cnt != '1) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      wait_cnt <= '0;
      // ready equals empty, so the handshake is just valid while empty
      if (valid && !prot_hit) begin
        full      <= 1'b1;
        slot_reg  <= in_reg;
        slot_data <= in_data;
      end
    end
  end

  assign starving = (wait_cnt >= WAIT_W'(STARVE_LIMIT));

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between CPU writeback (priority) and
// NUM_REQ peripheral holding slots served round-robin; all outputs registered.
module regfile_write_arbiter
  import regwr_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  input  logic                      cpu_we,
  input  logic [4:0]                cpu_wreg,
  input  logic [31:0]               cpu_wdata,
  output logic                      cpu_stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [5*NUM_REQ-1:0]      req_reg,
  input  logic [32*NUM_REQ-1:0]     req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ctrl_writeEnable,
  output logic [4:0]                ctrl_writeReg,
  output logic [31:0]               data_writeReg,
  output logic [3:0]                grant_src,
  output logic                      prot_err
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    full;
  logic [NUM_REQ-1:0]    starving;
  logic [NUM_REQ-1:0]    prot_hit;
  logic [NUM_REQ-1:0]    grant;
  logic [REG_ADDR_W-1:0] slot_reg  [NUM_REQ];
  logic [DATA_W-1:0]     slot_data [NUM_REQ];

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] win_next;
  logic             found;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign prot_hit[i] = is_protected(req_reg[5*i +: 5]);

    regwr_slot #(
      .STARVE_LIMIT (STARVE_LIMIT)
    ) u_slot (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .valid      (req_valid[i]),
      .prot_hit   (prot_hit[i]),
      .grant      (grant[i]),
      .in_reg     (req_reg[5*i +: 5]),
      .in_data    (req_data[32*i +: 32]),
      .full       (full[i]),
      .slot_reg   (slot_reg[i]),
      .slot_data  (slot_data[i]),
      .starving   (starving[i])
    );
  end

  assign req_ready = ~full;

  // Search full slots starting at rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && full[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (!cpu_we && found) grant[win] = 1'b1;
  end

  assign win_next = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      grant_src        <= GRANT_IDLE;
      rr_ptr           <= '0;
      cpu_stall        <= 1'b0;
      prot_err         <= 1'b0;
    end else begin
      cpu_stall <= |starving;
      if (|(req_valid & req_ready & prot_hit)) prot_err <= 1'b1;

      if (cpu_we) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= cpu_wreg;
        data_writeReg    <= cpu_wdata;
        grant_src        <= GRANT_CPU;
      end else if (found) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= slot_reg[win];
        data_writeReg    <= slot_data[win];
        grant_src        <= grant_req(32'(win));
        rr_ptr           <= win_next;
      end else begin
        ctrl_writeEnable <= 1'b0;
        grant_src        <= GRANT_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a behavioural model of slots and arbitration.
module tb_regfile_write_arbiter;

  localparam int N     = 4;
  localparam int LIMIT = 16;

  logic          clock;
  logic          ctrl_reset;
  logic          cpu_we;
  logic [4:0]    cpu_wreg;
  logic [31:0]   cpu_wdata;
  logic          cpu_stall;
  logic [N-1:0]  req_valid;
  logic [5*N-1:0]  req_reg;
  logic [32*N-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          ctrl_writeEnable;
  logic [4:0]    ctrl_writeReg;
  logic [31:0]   data_writeReg;
  logic [3:0]    grant_src;
  logic          prot_err;

  regfile_write_arbiter #(
    .NUM_REQ      (N),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .cpu_we           (cpu_we),
    .cpu_wreg         (cpu_wreg),
    .cpu_wdata        (cpu_wdata),
    .cpu_stall        (cpu_stall),
    .req_valid        (req_valid),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .grant_src        (grant_src),
    .prot_err         (prot_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model state
  bit          m_full [N];
  logic [4:0]  m_reg  [N];
  logic [31:0] m_data [N];
  int          m_wait [N];
  bit          m_xfer [N];
  int          m_rr;
  bit          m_we, m_stall, m_perr;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  int          m_src;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0; m_reg[i] = '0; m_data[i] = '0; m_wait[i] = 0; m_xfer[i] = 0;
    end
    m_rr = 0; m_we = 0; m_stall = 0; m_perr = 0; m_wreg = '0; m_wdata = '0; m_src = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied
  task automatic model_step();
    int win;
    bit stall_next;
    logic [4:0] r;
    stall_next = 0;
    for (int i = 0; i < N; i++) if (m_wait[i] >= LIMIT) stall_next = 1;
    win = -1;
    if (!cpu_we) begin
      for (int k = 0; k < N; k++) begin
        if (m_full[(m_rr + k) % N]) begin
          win = (m_rr + k) % N;
          break;
        end
      end
    end
    if (cpu_we) begin
      m_we = 1; m_wreg = cpu_wreg; m_wdata = cpu_wdata; m_src = 0;
    end else if (win >= 0) begin
      m_we = 1; m_wreg = m_reg[win]; m_wdata = m_data[win]; m_src = win + 1;
      m_rr = (win + 1) % N;
    end else begin
      m_we = 0; m_src = 0;
    end
    for (int i = 0; i < N; i++) begin
      m_xfer[i] = 0;
      if (m_full[i]) begin
        if (i == win) begin
          m_full[i] = 0; m_wait[i] = 0;
        end else if (m_wait[i] < 255) begin
          m_wait[i]++;
        end
      end else begin
        m_wait[i] = 0;
        if (req_valid[i]) begin
          m_xfer[i] = 1;
          r = req_reg[5*i +: 5];
          if (r == 5'd0 || r == 5'd29) m_perr = 1;
          else begin
            m_full[i] = 1; m_reg[i] = r; m_data[i] = req_data[32*i +: 32];
          end
        end
      end
    end
    m_stall = stall_next;
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_ready;
    for (int i = 0; i < N; i++) exp_ready[i] = !m_full[i];
    check("we", 32'(ctrl_writeEnable), 32'(m_we));
    check("wreg", 32'(ctrl_writeReg), 32'(m_wreg));
    check("wdata", data_writeReg, m_wdata);
    check("src", 32'(grant_src), 32'(m_src));
    check("stall", 32'(cpu_stall), 32'(m_stall));
    check("perr", 32'(prot_err), 32'(m_perr));
    check("ready", 32'(req_ready), 32'(exp_ready));
  endtask

  // Requesters drop valid once their transfer edge has passed
  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check_outputs();
    for (int i = 0; i < N; i++) if (m_xfer[i]) req_valid[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [4:0] r, input logic [31:0] d);
    req_valid[i]        = 1'b1;
    req_reg[5*i +: 5]   = r;
    req_data[32*i +: 32] = d;
  endtask

  task automatic do_reset();
    ctrl_reset = 1'b0;
    cpu_we = 1'b0; cpu_wreg = '0; cpu_wdata = '0;
    req_valid = '0; req_reg = '0; req_data = '0;
    model_reset();
    @(posedge clock);
    #1;
    ctrl_reset = 1'b1;
    check_outputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    int n;
    int burst;
    ctrl_reset = 1'b1;
    cpu_we = 1'b0; cpu_wreg = '0; cpu_wdata = '0;
    req_valid = '0; req_reg = '0; req_data = '0;
    #1;

    // Reset release and single uncontended peripheral write
    do_reset();
    check("rst_ready", 32'(req_ready), 32'hF);
    check("rst_we", 32'(ctrl_writeEnable), 32'h0);
    send(2, 5'd12, 32'h1A);
    tick();
    tick();
    check("p2_we", 32'(ctrl_writeEnable), 32'h1);
    check("p2_reg", 32'(ctrl_writeReg), 32'd12);
    check("p2_data", data_writeReg, 32'h1A);
    check("p2_src", 32'(grant_src), 32'd3);

    // Contention: CPU first, then slot 0, then slot 3; pointer back at 0
    do_reset();
    send(0, 5'd4, 32'hA0A0);
    send(3, 5'd7, 32'hB3B3);
    tick();
    cpu_we = 1'b1; cpu_wreg = 5'd9; cpu_wdata = 32'hC0DE;
    tick();
    check("ct_cpu_src", 32'(grant_src), 32'd0);
    check("ct_cpu_reg", 32'(ctrl_writeReg), 32'd9);
    cpu_we = 1'b0;
    tick();
    check("ct_s0_src", 32'(grant_src), 32'd1);
    tick();
    check("ct_s3_src", 32'(grant_src), 32'd4);
    send(0, 5'd5, 32'h11); send(1, 5'd6, 32'h22);
    tick();
    tick();
    check("ct_rr0_src", 32'(grant_src), 32'd1);
    tick();
    tick();

    // Round-robin fairness with immediate refill
    do_reset();
    for (int t = 0; t < 13; t++) begin
      for (int i = 0; i < N; i++)
        if (!m_full[i] && !req_valid[i]) send(i, 5'(1 + $urandom_range(0, 27)), $urandom);
      tick();
      if (t >= 1) check("rr_seq", 32'(grant_src), 32'((t - 1) % N + 1));
    end
    req_valid = '0;
    for (int t = 0; t < 5; t++) tick();

    // Starvation under continuous CPU writes
    do_reset();
    cpu_we = 1'b1; cpu_wreg = 5'd3; cpu_wdata = 32'h3333;
    send(1, 5'd20, 32'h5150);
    tick();
    n = 0;
    do begin
      cpu_wdata = $urandom;
      tick();
      n++;
    end while (!cpu_stall && n < 40);
    check("starve_lat", 32'(n), 32'd17);
    cpu_we = 1'b0;
    tick();
    check("starve_src", 32'(grant_src), 32'd2);
    check("starve_data", data_writeReg, 32'h5150);
    tick();
    check("starve_clr", 32'(cpu_stall), 32'd0);

    // Protected destinations never fill a slot
    do_reset();
    send(0, 5'd29, 32'hDEAD);
    tick();
    check("prot29_ready", 32'(req_ready[0]), 32'd1);
    check("prot29_err", 32'(prot_err), 32'd1);
    send(0, 5'd0, 32'hBEEF);
    tick();
    tick();
    check("prot0_we", 32'(ctrl_writeEnable), 32'd0);
    check("prot0_err", 32'(prot_err), 32'd1);

    // Asynchronous reset with full slots and stall pending
    do_reset();
    cpu_we = 1'b1; cpu_wreg = 5'd8; cpu_wdata = 32'h8888;
    for (int i = 0; i < N; i++) send(i, 5'(i + 10), 32'(i * 3 + 1));
    for (int t = 0; t < 19; t++) tick();
    check("ar_stall_pre", 32'(cpu_stall), 32'd1);
    #2;
    ctrl_reset = 1'b0;
    #1;
    check("ar_we", 32'(ctrl_writeEnable), 32'd0);
    check("ar_reg", 32'(ctrl_writeReg), 32'd0);
    check("ar_data", data_writeReg, 32'd0);
    check("ar_src", 32'(grant_src), 32'd0);
    check("ar_stall", 32'(cpu_stall), 32'd0);
    check("ar_ready", 32'(req_ready), 32'hF);
    cpu_we = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    ctrl_reset = 1'b1;
    tick();
    check("ar_empty_we", 32'(ctrl_writeEnable), 32'd0);

    // Randomized traffic with CPU bursts
    do_reset();
    burst = 0;
    for (int c = 0; c < 600; c++) begin
      if (burst == 0 && $urandom_range(0, 7) == 0) burst = $urandom_range(1, 24);
      cpu_we    = (burst > 0) && (!m_stall || $urandom_range(0, 7) == 0);
      cpu_wreg  = 5'($urandom);
      cpu_wdata = $urandom;
      if (burst > 0) burst--;
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) send(i, 5'($urandom), $urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
